// File: rtl/mc_sched_pkg.sv
// Shared types and helpers for the DDR command scheduler.
package mc_sched_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, TURN = 2'd2} sched_state_e;
  typedef enum logic {DIR_RD = 1'b0, DIR_WR = 1'b1} dir_e;

  // Index width that never collapses to zero bits.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mc_rr_pick.sv
// Combinational round-robin picker: first set bit at or above base, wrapping.
module mc_rr_pick import mc_sched_pkg::*; #(
  parameter  int N  = 4,
  localparam int SW = src_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] base,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          any
);

  int k;

  // Walk offsets from far to near so the nearest request overwrites last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int off = N - 1; off >= 0; off--) begin
      k = int'(base) + off;
      if (k >= N) k = k - N;
      if (req[k]) begin
        gnt    = '0;
        gnt[k] = 1'b1;
        idx    = SW'(k);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mc_cmd_sched.sv
// Round-robin DDR command scheduler with direction batching and turnaround gap.
module mc_cmd_sched import mc_sched_pkg::*; #(
  parameter  int NREQ      = 4,
  parameter  int ADDR_W    = 28,
  parameter  int TURN_CYC  = 4,
  parameter  int MAX_BATCH = 8,
  localparam int SW        = src_w(NREQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_vld_i,
  input  logic [NREQ-1:0]        req_we_i,
  input  logic [NREQ*ADDR_W-1:0] req_addr_i,
  output logic [NREQ-1:0]        req_pop_o,
  output logic                   cmd_vld_o,
  input  logic                   cmd_rdy_i,
  output logic                   cmd_we_o,
  output logic [ADDR_W-1:0]      cmd_addr_o,
  output logic [SW-1:0]          cmd_src_o
);

  localparam int BW = $clog2(MAX_BATCH + 1);
  localparam int TW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;

  sched_state_e    state, state_nxt;
  dir_e            cur_dir;
  logic            dir_vld;
  logic [SW-1:0]   rr_base, base, win;
  logic [BW-1:0]   batch_cnt;
  logic [TW-1:0]   turn_cnt;
  logic [NREQ-1:0] same, opp, mask, gnt;
  logic            any, win_we, hs, arb, dir_chg, do_issue, do_turn;

  assign hs   = cmd_vld_o & cmd_rdy_i;
  assign same = req_vld_i & ~(req_we_i ^ {NREQ{cur_dir == DIR_WR}});
  assign opp  = req_vld_i & ~same;
  // A handshaking command moves the round-robin pointer past its source.
  assign base = (state == ISSUE) ?
                ((cmd_src_o == SW'(NREQ - 1)) ? '0 : cmd_src_o + 1'b1) : rr_base;

  always_comb begin
    if (!dir_vld)                                        mask = req_vld_i;
    else if (batch_cnt == BW'(MAX_BATCH) && opp != '0)   mask = opp;
    else if (same != '0)                                 mask = same;
    else                                                 mask = opp;
  end

  mc_rr_pick #(.N(NREQ)) u_pick (
    .req  (mask),
    .base (base),
    .gnt  (gnt),
    .idx  (win),
    .any  (any)
  );

  assign win_we   = req_we_i[win];
  assign arb      = (state == IDLE) || (state == ISSUE && cmd_rdy_i);
  assign dir_chg  = dir_vld && (win_we != (cur_dir == DIR_WR));
  assign do_issue = arb && any && (!dir_chg || TURN_CYC == 0);
  assign do_turn  = arb && any && dir_chg && TURN_CYC != 0;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (do_issue) state_nxt = ISSUE;
               else if (do_turn) state_nxt = TURN;
      ISSUE:   if (cmd_rdy_i) state_nxt = do_issue ? ISSUE : (do_turn ? TURN : IDLE);
      TURN:    if (turn_cnt == TW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_pop_o = (do_issue && !rst_i) ? gnt : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_vld_o  <= 1'b0;
      cmd_we_o   <= 1'b0;
      cmd_addr_o <= '0;
      cmd_src_o  <= '0;
      rr_base    <= '0;
      cur_dir    <= DIR_RD;
      dir_vld    <= 1'b0;
      batch_cnt  <= '0;
      turn_cnt   <= '0;
    end else begin
      if (hs) rr_base <= base;
      if (do_issue) begin
        cmd_vld_o  <= 1'b1;
        cmd_we_o   <= win_we;
        cmd_addr_o <= req_addr_i[int'(win)*ADDR_W +: ADDR_W];
        cmd_src_o  <= win;
        cur_dir    <= dir_e'(win_we);
        dir_vld    <= 1'b1;
        if (!dir_vld || dir_chg)              batch_cnt <= BW'(1);
        else if (batch_cnt != BW'(MAX_BATCH)) batch_cnt <= batch_cnt + 1'b1;
      end else if (hs) begin
        cmd_vld_o <= 1'b0;
      end
      if (do_turn) begin
        cur_dir   <= dir_e'(win_we);
        batch_cnt <= '0;
        turn_cnt  <= TW'(TURN_CYC);
      end else if (state == TURN) begin
        turn_cnt  <= turn_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mc_cmd_sched.sv
// Scoreboard bench for mc_cmd_sched: queue model feeds both a TURN_CYC=4 and a TURN_CYC=0 build.
module tb_mc_cmd_sched;
  import mc_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 28;

  typedef struct packed {
    logic          we;
    logic [1:0]    src;
    logic [AW-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cmd_rdy, sel0;
  logic [NREQ-1:0]    vld, we, vld_a, vld_b, pop_a, pop_b, pop;
  logic [NREQ*AW-1:0] addr;
  logic               cv_a, cv_b, cw_a, cw_b, cmd_vld, cmd_we;
  logic [AW-1:0]      ca_a, ca_b, cmd_addr;
  logic [1:0]         cs_a, cs_b, cmd_src;

  // Only the selected build sees requests; the other stays idle.
  assign vld_a    = sel0 ? '0 : vld;
  assign vld_b    = sel0 ? vld : '0;
  assign pop      = sel0 ? pop_b : pop_a;
  assign cmd_vld  = sel0 ? cv_b : cv_a;
  assign cmd_we   = sel0 ? cw_b : cw_a;
  assign cmd_addr = sel0 ? ca_b : ca_a;
  assign cmd_src  = sel0 ? cs_b : cs_a;

  mc_cmd_sched #(.NREQ(NREQ), .ADDR_W(AW), .TURN_CYC(4), .MAX_BATCH(8)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_vld_i(vld_a), .req_we_i(we), .req_addr_i(addr),
    .req_pop_o(pop_a), .cmd_vld_o(cv_a), .cmd_rdy_i(cmd_rdy), .cmd_we_o(cw_a),
    .cmd_addr_o(ca_a), .cmd_src_o(cs_a));

  mc_cmd_sched #(.NREQ(NREQ), .ADDR_W(AW), .TURN_CYC(0), .MAX_BATCH(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_vld_i(vld_b), .req_we_i(we), .req_addr_i(addr),
    .req_pop_o(pop_b), .cmd_vld_o(cv_b), .cmd_rdy_i(cmd_rdy), .cmd_we_o(cw_b),
    .cmd_addr_o(ca_b), .cmd_src_o(cs_b));

  // Requester FIFO model: head presented combinationally, advanced by pop.
  logic [AW:0] qmem [NREQ][64];
  logic [5:0]  qwr  [NREQ] = '{default: '0};
  logic [5:0]  qrd  [NREQ] = '{default: '0};
  int          pop_cnt = 0;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      vld[i]           = (qwr[i] != qrd[i]);
      we[i]            = qmem[i][qrd[i]][AW];
      addr[i*AW +: AW] = qmem[i][qrd[i]][AW-1:0];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (pop[i]) qrd[i] <= qrd[i] + 6'd1;
    pop_cnt <= pop_cnt + $countones(pop);
  end

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int q, input logic w, input logic [AW-1:0] a);
    qmem[q][qwr[q]] = {w, a};
    qwr[q]          = qwr[q] + 6'd1;
  endtask

  task automatic expect_cmd(input logic w, input logic [1:0] s, input logic [AW-1:0] a);
    exp_t e;
    e.we = w; e.src = s; e.addr = a;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget, output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every handshake must match the next expected command.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && cmd_vld && cmd_rdy) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_cmd actual=%h required=none", {cmd_we, cmd_src, cmd_addr});
        end else begin
          e = exp_q.pop_front();
          chk("cmd", {cmd_we, cmd_src, cmd_addr}, e);
        end
      end
    end
  end

  initial begin
    int cyc, p0;
    rst = 1'b1; cmd_rdy = 1'b0; sel0 = 1'b0;
    repeat (3) tick();
    chk("rst_vld",  cmd_vld,  0);
    chk("rst_we",   cmd_we,   0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_src",  cmd_src,  0);
    chk("rst_pop",  pop,      0);
    rst = 1'b0;

    // All four queues reading: strict rotation, no bubbles.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREQ; i++) begin
        push(i, 1'b0, AW'(28'h100 + i * 16 + k));
        expect_cmd(1'b0, 2'(i), AW'(28'h100 + i * 16 + k));
      end
    p0 = pop_cnt;
    cmd_rdy = 1'b1;
    drain(40, cyc);
    chk("t1_cycles", cyc, 9);
    chk("t1_pops", pop_cnt - p0, 8);
    chk("t1_idle", cmd_vld, 0);

    // Backpressure holds the command and blocks further pops.
    cmd_rdy = 1'b0;
    push(1, 1'b0, 28'h123); push(2, 1'b0, 28'h200);
    expect_cmd(1'b0, 2'd1, 28'h123); expect_cmd(1'b0, 2'd2, 28'h200);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_vld", cmd_vld, 1);
      chk("t2_addr", cmd_addr, 28'h123);
      chk("t2_pop", pop, 0);
    end
    cmd_rdy = 1'b1;
    tick();
    chk("t2_next", {cmd_vld, cmd_addr}, {1'b1, 28'h200});
    drain(20, cyc);

    // Read-to-write turnaround: four TURN cycles, one IDLE arbitration, then issue.
    push(2, 1'b1, 28'h300);
    expect_cmd(1'b1, 2'd2, 28'h300);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_turn", {u_dut.state, cmd_vld, pop}, {TURN, 1'b0, 4'b0000});
    end
    tick();
    chk("t3_idle_pop", {u_dut.state, pop}, {IDLE, 4'b0100});
    tick();
    chk("t3_wr", {cmd_vld, cmd_we}, 2'b11);
    drain(20, cyc);

    // Reset while holding a stalled command.
    cmd_rdy = 1'b0;
    push(1, 1'b1, 28'h600);
    tick();
    chk("t6_held", cmd_vld, 1);
    push(1, 1'b1, 28'h601);
    rst = 1'b1; cmd_rdy = 1'b1;
    #1;
    chk("t6_rst_pop", pop, 0);
    tick();
    chk("t6_vld", cmd_vld, 0);
    chk("t6_rr_base", u_dut.rr_base, 0);
    chk("t6_dir_vld", u_dut.dir_vld, 0);
    rst = 1'b0;
    expect_cmd(1'b1, 2'd1, 28'h601);
    drain(20, cyc);

    // Batching: 8 reads, turn, 8 writes, turn, 8 reads.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) push(0, 1'b0, AW'(28'h400 + k));
    for (int k = 0; k < 8; k++)  push(3, 1'b1, AW'(28'h480 + k));
    for (int k = 0; k < 8; k++)  expect_cmd(1'b0, 2'd0, AW'(28'h400 + k));
    for (int k = 0; k < 8; k++)  expect_cmd(1'b1, 2'd3, AW'(28'h480 + k));
    for (int k = 8; k < 16; k++) expect_cmd(1'b0, 2'd0, AW'(28'h400 + k));
    drain(100, cyc);
    chk("t4_cycles", cyc, 35);

    // Zero-turnaround build: direction flips back to back.
    sel0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(0, 1'(k % 2), AW'(28'h500 + k));
      expect_cmd(1'(k % 2), 2'd0, AW'(28'h500 + k));
    end
    drain(20, cyc);
    chk("t5_cycles", cyc, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
